frame_sequencer: RTL and testbench

Sequences the counter_frame reference-signal generator through a programmable list of frame profiles. Each profile sets period, start offset, duty and repeat count. Per profile the block:
- clears the counter,
- raises its start,
- waits for done,
- inserts an optional gap, then moves on.

It sits between the host register bank and counter_frame, on the 200 MHz reference clock.

---
 rtl/frame_seq_pkg.sv | 15 +
 rtl/frame_profile_ram.sv | 26 ++
 rtl/frame_sequencer.sv | 123 ++++++++++++
 tb/tb_frame_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared widths, state encoding and profile type for the frame sequencer
package frame_seq_pkg;
  localparam int PERIOD_W = 64;
  localparam int START_W = 32;
  localparam int DUTY_W = 16;
  localparam int CNT_W = 8;
  localparam int PROF_W = PERIOD_W + START_W + DUTY_W + CNT_W;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_GAP, S_DONE} state_t;
  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [START_W-1:0] start;
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0] cnt;
  } profile_t;
endpackage

// File: rtl/frame_profile_ram.sv
// frame_profile_ram: profile register file with sync write, async read and async clear
module frame_profile_ram
  import frame_seq_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  parameter int IDX_W = 2
) (
  input  logic ref_clk_200m,
  input  logic reset_n,
  input  logic we,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [PROF_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [PROF_W-1:0] rd_data
);
  profile_t mem_q [NUM_PROFILES];
  profile_t mem_d [NUM_PROFILES];
  always_comb begin
    for (int i = 0; i < NUM_PROFILES; i++) mem_d[i] = (we && wr_addr == IDX_W'(i)) ? profile_t'(wr_data) : mem_q[i];
  end
  always_ff @(posedge ref_clk_200m or negedge reset_n) begin
    if (!reset_n) for (int i = 0; i < NUM_PROFILES; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  end
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: plays a list of counter_frame profiles with optional gaps and looping
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  parameter int IDX_W = 2,
  parameter int GAP_W = 16
) (
  input  logic ref_clk_200m,
  input  logic reset_n,
  input  logic cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [63:0] cfg_period,
  input  logic [31:0] cfg_start,
  input  logic [15:0] cfg_duty,
  input  logic [7:0] cfg_cnt,
  input  logic [IDX_W:0] seq_len,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic loop_en,
  input  logic go,
  input  logic abort,
  input  logic cf_done,
  output logic cf_reset,
  output logic cf_start,
  output logic [63:0] cf_period,
  output logic [31:0] cf_start_pos,
  output logic [15:0] cf_duty,
  output logic [7:0] cf_cnt_nums,
  output logic busy,
  output logic [IDX_W-1:0] cur_idx,
  output logic seq_done
);
  localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(NUM_PROFILES);
  state_t state_q, state_d, adv_state;
  logic [IDX_W-1:0] idx_q, idx_d, adv_idx;
  logic [IDX_W:0] len_q, len_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d, gap_q, gap_d;
  logic cf_reset_q, cf_reset_d, cf_start_q, cf_start_d, busy_q, busy_d, seq_done_q, seq_done_d, last;
  profile_t prof_q, prof_d, rd_prof;
  frame_profile_ram #(.NUM_PROFILES(NUM_PROFILES), .IDX_W(IDX_W)) u_ram (
    .ref_clk_200m(ref_clk_200m),
    .reset_n(reset_n),
    .we(cfg_we),
    .wr_addr(cfg_addr),
    .wr_data({cfg_period, cfg_start, cfg_duty, cfg_cnt}),
    .rd_addr(idx_d),
    .rd_data(rd_prof)
  );
  always_comb begin
    last = {1'b0, idx_q} + (IDX_W+1)'(1) >= len_q;
    adv_state = (last && !loop_en) ? S_DONE : S_LOAD;
    adv_idx = !last ? idx_q + IDX_W'(1) : loop_en ? '0 : idx_q;
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    gap_len_d = gap_len_q;
    gap_d = gap_q;
    case (state_q)
      S_IDLE: if (go && !abort && seq_len != '0) begin
        state_d = S_LOAD;
        idx_d = '0;
        len_d = seq_len > MAX_LEN ? MAX_LEN : seq_len;
        gap_len_d = gap_cycles;
      end
      S_LOAD: state_d = S_ARM;
      S_ARM: state_d = S_RUN;
      S_RUN: if (cf_done) begin
        state_d = gap_len_q == '0 ? adv_state : S_GAP;
        idx_d = gap_len_q == '0 ? adv_idx : idx_q;
        gap_d = gap_len_q - GAP_W'(1);
      end
      S_GAP: begin
        state_d = gap_q == '0 ? adv_state : S_GAP;
        idx_d = gap_q == '0 ? adv_idx : idx_q;
        gap_d = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d = idx_q;
    end
    cf_reset_d = !(state_d inside {S_ARM, S_RUN});
    cf_start_d = state_d == S_RUN;
    busy_d = state_d != S_IDLE;
    seq_done_d = state_d == S_DONE;
    prof_d = state_d == S_LOAD ? rd_prof : prof_q;
  end
  always_ff @(posedge ref_clk_200m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      len_q <= '0;
      gap_len_q <= '0;
      gap_q <= '0;
      cf_reset_q <= 1'b1;
      cf_start_q <= 1'b0;
      busy_q <= 1'b0;
      seq_done_q <= 1'b0;
      prof_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      gap_len_q <= gap_len_d;
      gap_q <= gap_d;
      cf_reset_q <= cf_reset_d;
      cf_start_q <= cf_start_d;
      busy_q <= busy_d;
      seq_done_q <= seq_done_d;
      prof_q <= prof_d;
    end
  end
  assign cf_reset = cf_reset_q;
  assign cf_start = cf_start_q;
  assign busy = busy_q;
  assign seq_done = seq_done_q;
  assign cur_idx = idx_q;
  assign cf_period = prof_q.period;
  assign cf_start_pos = prof_q.start;
  assign cf_duty = prof_q.duty;
  assign cf_cnt_nums = prof_q.cnt;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized scoreboard bench for frame_sequencer
module tb_frame_sequencer;
  localparam int NP = 4;
  localparam int IW = 2;
  localparam int GW = 16;
  typedef struct {
    bit is_done;
    int idx;
    logic [119:0] prof;
    int lat;
    bit from_go;
    int rst;
  } exp_t;
  logic ref_clk_200m = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr;
  logic [63:0] cfg_period;
  logic [31:0] cfg_start;
  logic [15:0] cfg_duty;
  logic [7:0] cfg_cnt;
  logic [IW:0] seq_len;
  logic [GW-1:0] gap_cycles;
  logic loop_en = 1'b0;
  logic go = 1'b0;
  logic abort = 1'b0;
  logic cf_done = 1'b0;
  logic cf_reset, cf_start, busy, seq_done;
  logic [63:0] cf_period;
  logic [31:0] cf_start_pos;
  logic [15:0] cf_duty;
  logic [7:0] cf_cnt_nums;
  logic [IW-1:0] cur_idx;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_go = 0;
  int t_done = 0;
  int t_abort = 0;
  int run_starts = 0;
  int done_seen = 0;
  int abort_seen = 0;
  bit abort_at_done = 0;
  exp_t exp_q[$];
  logic [119:0] shadow [NP];
  frame_sequencer #(.NUM_PROFILES(NP), .IDX_W(IW), .GAP_W(GW)) dut (
    .ref_clk_200m(ref_clk_200m),
    .reset_n(reset_n),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_period(cfg_period),
    .cfg_start(cfg_start),
    .cfg_duty(cfg_duty),
    .cfg_cnt(cfg_cnt),
    .seq_len(seq_len),
    .gap_cycles(gap_cycles),
    .loop_en(loop_en),
    .go(go),
    .abort(abort),
    .cf_done(cf_done),
    .cf_reset(cf_reset),
    .cf_start(cf_start),
    .cf_period(cf_period),
    .cf_start_pos(cf_start_pos),
    .cf_duty(cf_duty),
    .cf_cnt_nums(cf_cnt_nums),
    .busy(busy),
    .cur_idx(cur_idx),
    .seq_done(seq_done)
  );
  always #5 ref_clk_200m = ~ref_clk_200m;
  always @(posedge ref_clk_200m) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [119:0] rnd();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[119:0];
  endfunction
  task automatic push_run(input int i, input int lat, input bit from_go, input int rst);
    exp_t e;
    e.is_done = 0;
    e.idx = i;
    e.prof = shadow[i];
    e.lat = lat;
    e.from_go = from_go;
    e.rst = rst;
    exp_q.push_back(e);
  endtask
  task automatic build(input int len, input int g, input int passes);
    exp_t e;
    int n;
    n = len > NP ? NP : len;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++) begin
        if (p == 0 && i == 0) push_run(0, 3, 1, 1);
        else push_run(i, g + 3, 0, g + 1);
      end
    e.is_done = 1;
    e.idx = 0;
    e.prof = '0;
    e.lat = g + 1;
    e.from_go = 0;
    e.rst = 0;
    exp_q.push_back(e);
  endtask
  task automatic wr(input int a, input logic [119:0] v);
    @(negedge ref_clk_200m);
    cfg_we = 1'b1;
    cfg_addr = IW'(a);
    {cfg_period, cfg_start, cfg_duty, cfg_cnt} = v;
    @(negedge ref_clk_200m);
    cfg_we = 1'b0;
    shadow[a] = v;
  endtask
  task automatic start(input int len, input int g);
    @(negedge ref_clk_200m);
    seq_len = (IW+1)'(len);
    gap_cycles = GW'(g);
    go = 1'b1;
    t_go = cyc;
    @(negedge ref_clk_200m);
    go = 1'b0;
  endtask
  task automatic pulse_go(input int len, input int g);
    @(negedge ref_clk_200m);
    seq_len = (IW+1)'(len);
    gap_cycles = GW'(g);
    go = 1'b1;
    @(negedge ref_clk_200m);
    go = 1'b0;
  endtask
  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_seen < target; i++) @(negedge ref_clk_200m);
    chk("seq_done_count", done_seen, target);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  task automatic wait_runs(input int target);
    for (int i = 0; i < 3000 && run_starts < target; i++) @(negedge ref_clk_200m);
    chk("run_start_count", run_starts, target);
  endtask
  initial begin : cf_model
    bit prev;
    int wait_n;
    prev = 0;
    wait_n = 0;
    forever begin
      @(negedge ref_clk_200m);
      cf_done = 1'b0;
      abort = 1'b0;
      if (!reset_n) begin
        prev = 0;
        wait_n = 0;
      end else begin
        if (cf_start && !prev) wait_n = $urandom_range(3, 6);
        else if (cf_start && wait_n > 0) begin
          wait_n--;
          if (wait_n == 0) begin
            cf_done = 1'b1;
            t_done = cyc;
            if (abort_at_done) begin
              abort = 1'b1;
              t_abort = cyc;
              abort_seen++;
            end
          end
        end
        prev = cf_start;
      end
    end
  end
  initial begin : monitor
    exp_t it;
    bit prev_start;
    bit post_done;
    int rst_cnt;
    prev_start = 0;
    post_done = 0;
    rst_cnt = 0;
    forever begin
      @(negedge ref_clk_200m);
      if (!reset_n) begin
        prev_start = 0;
        post_done = 0;
        rst_cnt = 0;
      end else begin
        if (post_done) begin
          chk("busy_after_done", busy, 0);
          chk("done_pulse_width", seq_done, 0);
          post_done = 0;
        end
        if (!busy) rst_cnt = 0;
        if (cf_start && !prev_start) begin
          run_starts++;
          chk("run_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            chk("run_kind", it.is_done, 0);
            chk("run_idx", cur_idx, it.idx);
            chk("run_cfg", {cf_period, cf_start_pos, cf_duty, cf_cnt_nums}, it.prof);
            chk("run_latency", cyc - (it.from_go ? t_go : t_done), it.lat);
            chk("run_reset_cycles", rst_cnt, it.rst);
          end
          rst_cnt = 0;
        end else if (cf_reset && busy) rst_cnt++;
        if (seq_done) begin
          done_seen++;
          chk("done_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            chk("done_kind", it.is_done, 1);
            chk("done_latency", cyc - t_done, it.lat);
          end
          post_done = 1;
        end
        prev_start = cf_start;
      end
    end
  end
  initial begin : stim
    int nd, rs, g, len;
    logic [119:0] nv;
    nd = 0;
    seq_len = '0;
    gap_cycles = '0;
    cfg_addr = '0;
    {cfg_period, cfg_start, cfg_duty, cfg_cnt} = '0;
    for (int i = 0; i < NP; i++) shadow[i] = '0;
    repeat (2) @(negedge ref_clk_200m);
    chk("rst_cf_reset", cf_reset, 1);
    chk("rst_cf_start", cf_start, 0);
    chk("rst_cfg", {cf_period, cf_start_pos, cf_duty, cf_cnt_nums}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_seq_done", seq_done, 0);
    reset_n = 1'b1;
    wr(0, {64'd100, 32'd10, 16'd20, 8'd3});
    build(1, 0, 1);
    start(1, 0);
    wait_done(++nd);
    for (int i = 0; i < NP; i++) wr(i, rnd());
    build(3, 5, 1);
    start(3, 5);
    wait_done(++nd);
    loop_en = 1'b1;
    g = $urandom_range(0, 3);
    rs = run_starts;
    build(2, g, 2);
    start(2, g);
    wait_runs(rs + 3);
    loop_en = 1'b0;
    wait_done(++nd);
    @(negedge ref_clk_200m);
    seq_len = '0;
    go = 1'b1;
    @(negedge ref_clk_200m);
    go = 1'b0;
    chk("zero_len_busy", busy, 0);
    @(negedge ref_clk_200m);
    chk("zero_len_busy_late", busy, 0);
    g = $urandom_range(0, 3);
    rs = run_starts;
    build(7, g, 1);
    start(7, g);
    wait_runs(rs + 1);
    pulse_go(1, g + 7);
    chk("busy_go_busy", busy, 1);
    wait_done(++nd);
    rs = abort_seen;
    abort_at_done = 1;
    push_run(0, 3, 1, 1);
    start(1, 0);
    for (int i = 0; i < 500 && abort_seen == rs; i++) @(negedge ref_clk_200m);
    chk("abort_issued", abort_seen, rs + 1);
    abort_at_done = 0;
    while (cyc < t_abort + 1) @(negedge ref_clk_200m);
    chk("abort_busy", busy, 0);
    chk("abort_cf_reset", cf_reset, 1);
    chk("abort_cf_start", cf_start, 0);
    chk("abort_seq_done", seq_done, 0);
    chk("abort_queue", exp_q.size(), 0);
    seq_len = 1;
    gap_cycles = '0;
    go = 1'b1;
    t_go = cyc;
    build(1, 0, 1);
    @(negedge ref_clk_200m);
    go = 1'b0;
    wait_done(++nd);
    g = $urandom_range(0, 3);
    nv = rnd();
    shadow[1] = nv;
    rs = run_starts;
    build(2, g, 1);
    start(2, g);
    wait_runs(rs + 1);
    wr(1, nv);
    wait_done(++nd);
    rs = run_starts;
    build(2, 0, 1);
    start(2, 0);
    wait_runs(rs + 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_cf_reset", cf_reset, 1);
    chk("async_cf_start", cf_start, 0);
    chk("async_cfg", {cf_period, cf_start_pos, cf_duty, cf_cnt_nums}, 0);
    chk("async_busy", busy, 0);
    chk("async_cur_idx", cur_idx, 0);
    chk("async_seq_done", seq_done, 0);
    exp_q.delete();
    for (int i = 0; i < NP; i++) shadow[i] = '0;
    @(negedge ref_clk_200m);
    reset_n = 1'b1;
    build(2, 1, 1);
    start(2, 1);
    wait_done(++nd);
    repeat (6) begin
      repeat ($urandom_range(0, 2)) wr($urandom_range(0, NP - 1), rnd());
      len = $urandom_range(1, 7);
      g = $urandom_range(0, 4);
      build(len, g, 1);
      start(len, g);
      wait_done(++nd);
    end
    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
